// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and helpers for the traffic lamp driver
package traffic_pkg;

  localparam int NUM_ROADS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GREEN = 3'd1,
    AMBER = 3'd2,
    CLEAR = 3'd3,
    FLASH = 3'd4
  } lamp_state_t;

  typedef logic [1:0] road_t;

  // Legal grants are all-zero or exactly one bit set.
  function automatic logic grant_legal(input logic [NUM_ROADS-1:0] g);
    return ((g & (g - 1'b1)) == '0);
  endfunction

  function automatic road_t onehot_to_road(input logic [NUM_ROADS-1:0] g);
    road_t r;
    r = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (g[i]) r = road_t'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_ROADS-1:0] road_to_onehot(input road_t r);
    return ({{(NUM_ROADS-1){1'b0}}, 1'b1} << r);
  endfunction

endpackage

// File: rtl/tld_phase_timer.sv
// rtl/tld_phase_timer.sv - loadable saturating down-counter for phase timing
module tld_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Stops at zero so an idle timer never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/traffic_lamp_driver.sv
// rtl/traffic_lamp_driver.sv - grant-to-lamp sequencer (green/amber/clear)
// Optional TLD_FAULT_FLASH_EN: flashing amber lockout after an illegal grant.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int AMBER_CYC = 3,
  parameter int CLEAR_CYC = 2,
  parameter int FLASH_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ROADS-1:0] grant,
  output logic [NUM_ROADS-1:0] lamp_red,
  output logic [NUM_ROADS-1:0] lamp_amber,
  output logic [NUM_ROADS-1:0] lamp_green,
  output logic                 busy,
  output logic                 fault
);

  localparam int MAX_AC = (AMBER_CYC > CLEAR_CYC) ? AMBER_CYC : CLEAR_CYC;
  localparam int MAX_C  = (MAX_AC > FLASH_CYC) ? MAX_AC : FLASH_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  lamp_state_t          state, state_d;
  road_t                cur, cur_d;
  logic                 legal, fault_d;
  logic [NUM_ROADS-1:0] geff;
  logic                 tmr_load, tmr_done;
  logic [CW-1:0]        tmr_val;
  logic [NUM_ROADS-1:0] red_d, amber_d, green_d;
  logic                 busy_d;

  tld_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    legal    = grant_legal(grant);
    geff     = legal ? grant : '0;
    fault_d  = fault | ~legal;
    state_d  = state;
    cur_d    = cur;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state)
      IDLE: begin
`ifdef TLD_FAULT_FLASH_EN
        if (fault_d) begin
          state_d  = FLASH;
          tmr_load = 1'b1;
          tmr_val  = CW'(FLASH_CYC - 1);
        end else
`endif
        if (geff != '0) begin
          cur_d   = onehot_to_road(geff);
          state_d = GREEN;
        end
      end
      GREEN: begin
        if (geff != road_to_onehot(cur)) begin
          state_d  = AMBER;
          tmr_load = 1'b1;
          tmr_val  = CW'(AMBER_CYC - 1);
        end
      end
      AMBER: begin
        if (tmr_done) begin
          state_d  = CLEAR;
          tmr_load = 1'b1;
          tmr_val  = CW'(CLEAR_CYC - 1);
        end
      end
      CLEAR: begin
        // Grant is only honoured on the final clearance cycle.
        if (tmr_done) begin
`ifdef TLD_FAULT_FLASH_EN
          if (fault_d) begin
            state_d  = FLASH;
            tmr_load = 1'b1;
            tmr_val  = CW'(FLASH_CYC - 1);
          end else
`endif
          if (geff != '0) begin
            cur_d   = onehot_to_road(geff);
            state_d = GREEN;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef TLD_FAULT_FLASH_EN
      FLASH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CW'(FLASH_CYC - 1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    red_d   = '1;
    amber_d = '0;
    green_d = '0;
    case (state_d)
      GREEN: begin
        green_d = road_to_onehot(cur_d);
        red_d   = ~road_to_onehot(cur_d);
      end
      AMBER: begin
        amber_d = road_to_onehot(cur_d);
        red_d   = ~road_to_onehot(cur_d);
      end
`ifdef TLD_FAULT_FLASH_EN
      FLASH: begin
        red_d = '0;
        if (state != FLASH) amber_d = '1;
        else                amber_d = tmr_done ? ~lamp_amber : lamp_amber;
      end
`endif
      default: red_d = '1;
    endcase
    busy_d = (state_d == AMBER) || (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur        <= '0;
      fault      <= 1'b0;
      lamp_red   <= '1;
      lamp_amber <= '0;
      lamp_green <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cur        <= cur_d;
      fault      <= fault_d;
      lamp_red   <= red_d;
      lamp_amber <= amber_d;
      lamp_green <= green_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// tb/tb_traffic_lamp_driver.sv - directed self-checking bench for traffic_lamp_driver
module tb_traffic_lamp_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] grant = 4'h0;
  logic [3:0] lamp_red, lamp_amber, lamp_green;
  logic       busy, fault;

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_fault = 1'b0;

  traffic_lamp_driver dut (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant),
    .lamp_red   (lamp_red),
    .lamp_amber (lamp_amber),
    .lamp_green (lamp_green),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] v(input logic [3:0] r, input logic [3:0] a,
                                     input logic [3:0] g, input logic b, input logic f);
    return {r, a, g, b, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {lamp_red, lamp_amber, lamp_green, busy, fault};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed r/a/g/b/f=%h expected %h", tag, obs, exp);
    end
  endtask

  // Grant already changed: 3 amber cycles on `from`, 2 clear cycles, then green `to` or idle.
  task automatic change(input string tag, input logic [3:0] from, input logic [3:0] to);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_amber"}, v(~from, from, 4'h0, 1'b1, exp_fault));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_clear"}, v(4'hF, 4'h0, 4'h0, 1'b1, exp_fault));
    end
    tick();
    if (to != 4'h0) chk({tag, "_green"}, v(~to, 4'h0, to, 1'b0, exp_fault));
    else            chk({tag, "_idle"}, v(4'hF, 4'h0, 4'h0, 1'b0, exp_fault));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 chk("reset_async", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
    tick();
    chk("reset_hold", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
    rst = 1'b1;
    tick();
    chk("idle", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));

    grant = 4'b0001;
    tick();
    chk("g1_from_idle", v(4'b1110, 4'h0, 4'b0001, 1'b0, 1'b0));
    tick();
    chk("g1_hold", v(4'b1110, 4'h0, 4'b0001, 1'b0, 1'b0));

    grant = 4'b0100;
    change("t1_to_t3", 4'b0001, 4'b0100);

    // Grant bounces back to the current road during amber: no re-green until after clear.
    grant = 4'b0001;
    tick();
    chk("bounce_amber0", v(4'b1011, 4'b0100, 4'h0, 1'b1, 1'b0));
    grant = 4'b0100;
    tick();
    chk("bounce_amber1", v(4'b1011, 4'b0100, 4'h0, 1'b1, 1'b0));
    tick();
    chk("bounce_amber2", v(4'b1011, 4'b0100, 4'h0, 1'b1, 1'b0));
    tick();
    chk("bounce_clear0", v(4'hF, 4'h0, 4'h0, 1'b1, 1'b0));
    tick();
    chk("bounce_clear1", v(4'hF, 4'h0, 4'h0, 1'b1, 1'b0));
    tick();
    chk("bounce_regreen", v(4'b1011, 4'h0, 4'b0100, 1'b0, 1'b0));

    grant = 4'b0010;
    change("t3_to_t2", 4'b0100, 4'b0010);
    grant = 4'b0000;
    change("t2_to_idle", 4'b0010, 4'b0000);
    tick();
    chk("idle_stay", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
    grant = 4'b1000;
    tick();
    chk("g4_from_idle", v(4'b0111, 4'h0, 4'b1000, 1'b0, 1'b0));
    grant = 4'b0000;
    change("t4_to_idle", 4'b1000, 4'b0000);
    grant = 4'b0001;
    tick();
    chk("g1_again", v(4'b1110, 4'h0, 4'b0001, 1'b0, 1'b0));

    // Illegal grant while T1 green.
    grant = 4'b0011;
    exp_fault = 1'b1;
    tick();
    chk("illegal_amber0", v(4'b1110, 4'b0001, 4'h0, 1'b1, 1'b1));
    grant = 4'b0000;
    tick();
    chk("illegal_amber1", v(4'b1110, 4'b0001, 4'h0, 1'b1, 1'b1));
    tick();
    chk("illegal_amber2", v(4'b1110, 4'b0001, 4'h0, 1'b1, 1'b1));
    tick();
    chk("illegal_clear0", v(4'hF, 4'h0, 4'h0, 1'b1, 1'b1));
    tick();
    chk("illegal_clear1", v(4'hF, 4'h0, 4'h0, 1'b1, 1'b1));
    grant = 4'b0010;
    tick();
`ifdef TLD_FAULT_FLASH_EN
    chk("flash_lit0", v(4'h0, 4'hF, 4'h0, 1'b0, 1'b1));
    tick();
    chk("flash_dark0", v(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
    tick();
    chk("flash_lit1", v(4'h0, 4'hF, 4'h0, 1'b0, 1'b1));
    grant = 4'b0100;
    tick();
    chk("flash_dark1", v(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
    #3 rst = 1'b0;
    #1 chk("reset_in_flash", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
`else
    chk("fault_then_g2", v(4'b1101, 4'h0, 4'b0010, 1'b0, 1'b1));

    // Illegal grant on the last clear cycle lands in idle.
    grant = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lastclr_amber", v(4'b1101, 4'b0010, 4'h0, 1'b1, 1'b1));
    end
    tick();
    chk("lastclr_clear0", v(4'hF, 4'h0, 4'h0, 1'b1, 1'b1));
    tick();
    chk("lastclr_clear1", v(4'hF, 4'h0, 4'h0, 1'b1, 1'b1));
    grant = 4'b0011;
    tick();
    chk("lastclr_illegal_idle", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b1));

    grant = 4'b0100;
    tick();
    chk("g3_fault_sticky", v(4'b1011, 4'h0, 4'b0100, 1'b0, 1'b1));
    grant = 4'b0000;
    tick();
    chk("pre_reset_amber", v(4'b1011, 4'b0100, 4'h0, 1'b1, 1'b1));
    #3 rst = 1'b0;
    #1 chk("reset_mid_amber", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
`endif
    grant = 4'b0100;
    tick();
    chk("reset_held", v(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
    rst = 1'b1;
    tick();
    chk("after_reset_g3", v(4'b1011, 4'h0, 4'b0100, 1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
- Downstream consumer of the traffic controller's one-hot grant vector `traffic[4:1]`.
- Converts each grant change into a safe lamp sequence per road: green, then amber, then all-red clearance, then the next green.
- Drives the physical red/amber/green lamp outputs for roads T1..T4 and flags illegal grant patterns.
- Clock is the system 1 s tick; all timing parameters are in clock cycles.

Parameters:
- AMBER_CYC, 3, cycles amber is held after a green is withdrawn (min 1)
- CLEAR_CYC, 2, cycles of all-red clearance before any new green (min 1)
- FLASH_CYC, 1, half-period in cycles of the fault amber flash (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- grant  in  4  grant from traffic controller, bit k = road Tk; legal values are zero or one-hot
- lamp_red  out  4  red lamp per road
- lamp_amber  out  4  amber lamp per road
- lamp_green  out  4  green lamp per road
- busy  out  1  high while in AMBER or CLEAR
- fault  out  1  sticky illegal-grant flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, lamp_red=4'b1111, lamp_amber=0, lamp_green=0, busy=0, fault=0.
  - Counters and the latched road are cleared.
- States:
  - IDLE: all red.
  - GREEN: road `cur` green, all others red.
  - AMBER: road `cur` amber, others red.
  - CLEAR: all red.
- Per road, exactly one lamp is lit at all times; outputs are registered.
- `grant` is sampled every rising edge. An illegal grant (two or more bits set) sets fault=1 (sticky until reset) and is treated as grant=0 for that cycle.
- IDLE:
  - Grant one-hot road k: latch cur=k, go to GREEN next cycle. Lamp_green[k] rises one cycle after grant is seen.
  - Grant zero: stay in IDLE.
- GREEN:
  - grant==one-hot(cur): hold.
  - Any other value (zero, other road, illegal): go to AMBER and load the counter with AMBER_CYC-1.
- AMBER:
  - Lasts exactly AMBER_CYC cycles regardless of grant. No re-green from AMBER, even if grant returns to cur.
  - Then go to CLEAR with the counter loaded to CLEAR_CYC-1.
- CLEAR:
  - Lasts exactly CLEAR_CYC cycles.
  - On the last cycle, sample grant: one-hot road j → cur=j, go to GREEN; otherwise go to IDLE.
  - Grant changes during CLEAR before the last cycle are ignored.
- Latency:
  - Minimum from grant change to new green: 1 + AMBER_CYC + CLEAR_CYC cycles (defaults: 6).
  - From IDLE: 1 cycle.
- Counter width is $clog2(max(AMBER_CYC, CLEAR_CYC, FLASH_CYC)+1). The counter decrements to 0; no wrap-around is permitted.
- busy = (state==AMBER || state==CLEAR).
- Simultaneous events: reset dominates everything. An illegal grant arriving on the last CLEAR cycle goes to IDLE with fault=1.

Optional Feature:
- Macro: TLD_FAULT_FLASH_EN.
- Defined:
  - Once fault=1, the FSM finishes any in-flight AMBER/CLEAR, then enters FLASH.
  - In FLASH, lamp_red=0, lamp_green=0, and lamp_amber=4'b1111 toggles with 4'b0000 every FLASH_CYC cycles, starting lit.
  - Grant is ignored; only reset exits FLASH.
- Undefined: fault is a flag only and normal sequencing continues; there is no FLASH state and no flash logic.

Decomposition:
- Shared package traffic_pkg:
  - NUM_ROADS=4.
  - lamp state enum (IDLE, GREEN, AMBER, CLEAR, FLASH).
  - road index type (2-bit).
  - one-hot legality check function.
- Sub-module tld_phase_timer: loadable down-counter with load value, load strobe and `done` output. Used for AMBER, CLEAR and FLASH timing.

Test Plan:
- Reset, then grant=0001 → next cycle green=0001, red=1110, busy=0.
- Green T1 held, grant→0100 → green T1 drops to amber=0001 for 3 cycles, then all red for 2 cycles, then green=0100. Total 6 cycles, busy=1 for 5 cycles.
- During AMBER of T1, grant returns to 0001 → sequence still completes. Green=0001 reasserted after CLEAR, never directly from AMBER.
- Green T2, grant→0000 → amber T2 for 3 cycles, CLEAR for 2 cycles, then IDLE all-red. Then grant=1000 → green=1000 after 1 cycle.
- grant=0011 while green T1 → fault=1 sticky and amber T1 starts. Without TLD_FAULT_FLASH_EN: grant=0010 after CLEAR → green T2. With the macro: amber 1111/0000 alternating each cycle after CLEAR, released only by rst=0.
- Assert rst=0 asynchronously mid-AMBER → outputs immediately red=1111, amber=0, green=0, fault=0.
